event_time_capture: RTL and testbench
=====================================

Name: event_time_capture

Overview:
Synthesizable observer that watches LANES independent WIDTH-bit buses and records every value change as a (lane, new value, cycle timestamp) event. Events go into a small FIFO that a consumer drains over a valid/ready handshake. It is the reading/observing end of timed-assignment test blocks. A bench drives timed outputs into it and checks the recorded change times in hardware rather than in simulation.

Parameters:
LANES, 5, number of monitored buses
WIDTH, 3, bits per bus
LANE_BITS, 3, width of lane index; must satisfy 2**LANE_BITS >= LANES
TS_WIDTH, 8, timestamp counter width
DEPTH, 8, FIFO entries; power of two
CNT_BITS, 4, width of level output; must equal log2(DEPTH)+1

Ports:
clk  input  1  rising-edge clock, only clock
rst  input  1  synchronous, active-high reset
lane_data  input  LANES*WIDTH  monitored buses; lane i = bits [i*WIDTH +: WIDTH]
arm  input  1  start/restart capture (1-cycle pulse)
stop  input  1  end capture, then drain
ev_valid  output  1  FIFO head valid
ev_ready  input  1  consumer accepts head
ev_lane  output  LANE_BITS  lane index of head event
ev_value  output  WIDTH  new lane value of head event
ev_time  output  TS_WIDTH  timestamp of head event
level  output  CNT_BITS  FIFO occupancy, 0..DEPTH
overflow  output  1  sticky: an event was lost
busy  output  1  state is RUN or DRAIN

Behaviour:
- Reset (rst=1 at clk edge, any state): state IDLE; FIFO emptied; pending slots cleared; timestamp=0.
- Reset output values: ev_valid=0, ev_lane=0, ev_value=0, ev_time=0, level=0, overflow=0, busy=0.
- rst has priority over arm/stop.
- States:
  - IDLE: no detection. On arm=1: capture baseline, then RUN.
  - RUN: detect and record changes. On stop=1 with arm=0: go to DRAIN.
  - DRAIN: no new detection; pending slots still flushed to FIFO. Go to IDLE when all pending slots are clear and level=0.
- Arm:
  - Arm cycle: baseline<=lane_data, ts<=0.
  - Arm in RUN or DRAIN re-arms: FIFO flushed, pending cleared, overflow cleared, baseline recaptured, ts<=0, state RUN.
  - arm and stop together: arm wins.
- Timestamp:
  - ts increments by 1 at the end of every RUN cycle.
  - Saturates at all-ones and does not wrap.
  - First RUN cycle after the arm edge has ts=0.
- Detection, RUN only:
  - Each cycle, lane i is changed when its field differs from baseline[i].
  - baseline<=lane_data every RUN cycle.
  - A changed lane loads its pending slot with value=new field, time=current ts.
  - If the slot was already pending and not drained this cycle, it is overwritten and overflow<=1.
- Push:
  - Each cycle at most one pending slot, the lowest index, is pushed into the FIFO.
  - Push is allowed when level<DEPTH, or when level=DEPTH and a pop occurs the same cycle.
  - The pushed slot clears unless a new change on that lane is detected the same cycle; in that case it reloads and no overflow is flagged.
  - A pending slot waits while the FIFO is full; no event is lost for that reason alone.
- FIFO:
  - First-word fall-through: head fields are valid whenever ev_valid=1.
  - Pop when ev_valid&&ev_ready.
  - level updates next cycle: +1 on push only, -1 on pop only, unchanged on both.
  - Latency: a change seen at cycle t with empty FIFO and no competing lanes gives ev_valid=1 at cycle t+2.
  - ev_* hold stable while ev_valid=1 and ev_ready=0.
- busy=1 exactly in RUN and DRAIN.

Test Plan:
- Basic timestamps: rst 2 cycles; arm with lane_data=0; lane1 goes to 3'b001 at ts 10, lane3 to 3'b100 at ts 20, lane4 to 3'b101 at ts 50; ev_ready=1 -> events in order (1,1,10), (3,4,20), (4,5,50); overflow=0.
- Simultaneous changes: lanes 0, 2 and 4 change in the same cycle at ts 5 -> three events, lane order 0, 2, 4, all with time 5, pushed on consecutive cycles.
- Backpressure and full: ev_ready=0; 9 single-lane changes -> level=8, 9th event waits pending with overflow=0. Then pop once -> 9th event enters in the same cycle and level stays 8.
- Overwrite overflow: ev_ready=0, FIFO full; lane2 changes at ts 3 and again at ts 4 -> overflow=1; after draining, the lane2 entry carries time 4.
- Saturation and stop: TS_WIDTH=8; hold 300 cycles, then change lane0 -> ev_time=255. Assert stop -> busy stays 1 until level=0, then IDLE; later changes produce no events.
- Reset mid-operation: rst with level=5 and pending slots set -> next cycle ev_valid=0, level=0, overflow=0, busy=0. A re-arm then captures from ts 0.

Source files
------------

// File: rtl/event_time_capture.sv
// Observes LANES buses and logs each value change as (lane, value, timestamp)
// into a first-word-fall-through FIFO drained over a valid/ready handshake.
module event_time_capture #(
    parameter int LANES     = 5,
    parameter int WIDTH     = 3,
    parameter int LANE_BITS = 3,
    parameter int TS_WIDTH  = 8,
    parameter int DEPTH     = 8,
    parameter int CNT_BITS  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*WIDTH-1:0] lane_data,
    input  logic                   arm,
    input  logic                   stop,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [LANE_BITS-1:0]   ev_lane,
    output logic [WIDTH-1:0]       ev_value,
    output logic [TS_WIDTH-1:0]    ev_time,
    output logic [CNT_BITS-1:0]    level,
    output logic                   overflow,
    output logic                   busy
);

    localparam int ADDR_BITS = CNT_BITS - 1;
    localparam int ENTRY_W   = LANE_BITS + WIDTH + TS_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LANES*WIDTH-1:0] r_base;
    logic [TS_WIDTH-1:0]    r_ts;
    logic [LANES-1:0]       r_pend_valid;
    logic [WIDTH-1:0]       r_pend_value [LANES];
    logic [TS_WIDTH-1:0]    r_pend_time  [LANES];
    logic [ENTRY_W-1:0]     r_mem        [DEPTH];
    logic [ADDR_BITS-1:0]   r_wr_ptr;
    logic [ADDR_BITS-1:0]   r_rd_ptr;
    logic [CNT_BITS-1:0]    r_level;
    logic                   r_overflow;

    logic                   w_run;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_pend_any;
    logic                   w_ovf_event;
    logic [LANE_BITS-1:0]   w_push_idx;
    logic [LANES-1:0]       w_changed;
    logic [LANES-1:0]       w_push_onehot;
    logic [ENTRY_W-1:0]     w_head;
    logic [ENTRY_W-1:0]     w_push_entry;

    // arm takes over the cycle entirely, so detection and pushes are suppressed
    assign w_run    = (r_state == S_RUN) && !arm;
    assign w_full   = (r_level == CNT_BITS'(DEPTH));
    assign ev_valid = (r_level != '0);
    assign w_pop    = ev_valid && ev_ready;
    assign w_push   = w_pend_any && (!w_full || w_pop) && !arm;

    always_comb begin
        w_push_idx = '0;
        w_pend_any = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (r_pend_valid[i]) begin
                w_push_idx = LANE_BITS'(i);
                w_pend_any = 1'b1;
            end
        end
    end

    assign w_push_entry = {w_push_idx, r_pend_value[w_push_idx], r_pend_time[w_push_idx]};
    assign w_ovf_event  = |(w_changed & r_pend_valid & ~w_push_onehot);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_changed[gi] = w_run &&
                (lane_data[gi*WIDTH +: WIDTH] != r_base[gi*WIDTH +: WIDTH]);
            assign w_push_onehot[gi] = w_push && (w_push_idx == LANE_BITS'(gi));

            // a fresh change wins over the slot's own push, so it reloads
            always_ff @(posedge clk) begin
                if (rst || arm) begin
                    r_pend_valid[gi] <= 1'b0;
                end else if (w_changed[gi]) begin
                    r_pend_valid[gi] <= 1'b1;
                    r_pend_value[gi] <= lane_data[gi*WIDTH +: WIDTH];
                    r_pend_time[gi]  <= r_ts;
                end else if (w_push_onehot[gi]) begin
                    r_pend_valid[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (arm) w_state_next = S_RUN;
            S_RUN: begin
                if (arm)       w_state_next = S_RUN;
                else if (stop) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (arm)
                    w_state_next = S_RUN;
                else if (!w_pend_any && (r_level == '0))
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ts       <= '0;
            r_base     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (arm) begin
                r_ts       <= '0;
                r_base     <= lane_data;
                r_overflow <= 1'b0;
            end else if (w_run) begin
                r_base <= lane_data;
                if (r_ts != '1)
                    r_ts <= r_ts + TS_WIDTH'(1);
                if (w_ovf_event)
                    r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || arm) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + CNT_BITS'(1);
                2'b01:   r_level <= r_level - CNT_BITS'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // storage array without reset; read is through r_rd_ptr for fall-through
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_push_entry;
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign ev_lane  = ev_valid ? w_head[ENTRY_W-1 -: LANE_BITS] : '0;
    assign ev_value = ev_valid ? w_head[TS_WIDTH +: WIDTH]      : '0;
    assign ev_time  = ev_valid ? w_head[TS_WIDTH-1:0]           : '0;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_event_time_capture.sv
// Bench for event_time_capture: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_event_time_capture;

    localparam int LANES     = 5;
    localparam int WIDTH     = 3;
    localparam int LANE_BITS = 3;
    localparam int TS_WIDTH  = 8;
    localparam int DEPTH     = 8;
    localparam int CNT_BITS  = 4;
    localparam int TS_MAX    = (1 << TS_WIDTH) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [LANES*WIDTH-1:0] lane_data;
    logic                   arm;
    logic                   stop;
    logic                   ev_valid;
    logic                   ev_ready;
    logic [LANE_BITS-1:0]   ev_lane;
    logic [WIDTH-1:0]       ev_value;
    logic [TS_WIDTH-1:0]    ev_time;
    logic [CNT_BITS-1:0]    level;
    logic                   overflow;
    logic                   busy;

    always #5 clk = ~clk;

    event_time_capture #(
        .LANES(LANES), .WIDTH(WIDTH), .LANE_BITS(LANE_BITS),
        .TS_WIDTH(TS_WIDTH), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk), .rst(rst), .lane_data(lane_data), .arm(arm), .stop(stop),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_lane(ev_lane),
        .ev_value(ev_value), .ev_time(ev_time), .level(level),
        .overflow(overflow), .busy(busy)
    );

    typedef struct {
        int lane;
        int value;
        int t;
    } ev_t;

    // reference model: 0=IDLE 1=RUN 2=DRAIN
    int  m_state;
    int  m_base [LANES];
    int  m_ts;
    bit  m_pv   [LANES];
    int  m_pval [LANES];
    int  m_pt   [LANES];
    bit  m_ovf;
    ev_t m_fifo [$];
    ev_t popped [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int field(input logic [LANES*WIDTH-1:0] ld, input int i);
        return int'((ld >> (i * WIDTH)) & ((1 << WIDTH) - 1));
    endfunction

    task automatic set_lane(input int i, input int v);
        lane_data[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic model_step();
        bit  drain_done;
        bit  pop;
        bit  push;
        int  pidx;
        ev_t e;
        if (rst) begin
            m_state = 0; m_ts = 0; m_ovf = 0;
            m_fifo.delete();
            for (int i = 0; i < LANES; i++) m_pv[i] = 0;
            return;
        end
        if (arm) begin
            m_state = 1; m_ts = 0; m_ovf = 0;
            m_fifo.delete();
            for (int i = 0; i < LANES; i++) begin
                m_pv[i]   = 0;
                m_base[i] = field(lane_data, i);
            end
            return;
        end
        drain_done = (m_state == 2) && (m_fifo.size() == 0);
        pidx = -1;
        for (int i = LANES - 1; i >= 0; i--) if (m_pv[i]) pidx = i;
        if (pidx >= 0) drain_done = 0;
        pop  = (m_fifo.size() > 0) && ev_ready;
        push = (pidx >= 0) && ((m_fifo.size() < DEPTH) || pop);
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            e.lane = pidx; e.value = m_pval[pidx]; e.t = m_pt[pidx];
            m_fifo.push_back(e);
            m_pv[pidx] = 0;
        end
        if (m_state == 1) begin
            for (int i = 0; i < LANES; i++) begin
                int f;
                f = field(lane_data, i);
                if (f != m_base[i]) begin
                    if (m_pv[i]) m_ovf = 1;
                    m_pv[i] = 1; m_pval[i] = f; m_pt[i] = m_ts;
                end
                m_base[i] = f;
            end
            if (m_ts < TS_MAX) m_ts++;
            if (stop) m_state = 2;
        end else if (drain_done) begin
            m_state = 0;
        end
    endtask

    // one clock: log any handshake, advance model, compare after the edge
    task automatic cyc();
        ev_t e;
        int  exp_head;
        if (ev_valid === 1'b1 && ev_ready) begin
            e.lane = int'(ev_lane); e.value = int'(ev_value); e.t = int'(ev_time);
            popped.push_back(e);
        end
        model_step();
        @(posedge clk);
        #1;
        exp_head = 0;
        if (m_fifo.size() > 0)
            exp_head = (m_fifo[0].lane << (WIDTH + TS_WIDTH)) | (m_fifo[0].value << TS_WIDTH) | m_fifo[0].t;
        check("ev_valid", 32'(ev_valid), (m_fifo.size() > 0) ? 1 : 0);
        check("ev_head", 32'({ev_lane, ev_value, ev_time}), exp_head);
        check("level", 32'(level), m_fifo.size());
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("busy", 32'(busy), (m_state != 0) ? 1 : 0);
    endtask

    task automatic check_event(input string tag, input int idx, input int lane, input int value, input int t);
        ev_t e;
        check({tag, "_present"}, (idx < popped.size()) ? 1 : 0, 1);
        if (idx < popped.size()) begin
            e = popped[idx];
            check({tag, "_lane"},  e.lane,  lane);
            check({tag, "_value"}, e.value, value);
            check({tag, "_time"},  e.t,     t);
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    initial begin
        int t2;
        rst = 1'b1; arm = 1'b0; stop = 1'b0; ev_ready = 1'b1; lane_data = '0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // basic timestamps
        popped.delete();
        do_arm();
        for (int k = 0; k < 70; k++) begin
            if (k == 10) set_lane(1, 1);
            if (k == 20) set_lane(3, 4);
            if (k == 50) set_lane(4, 5);
            cyc();
        end
        check("s1_count", popped.size(), 3);
        check_event("s1_e0", 0, 1, 1, 10);
        check_event("s1_e1", 1, 3, 4, 20);
        check_event("s1_e2", 2, 4, 5, 50);
        check("s1_overflow", 32'(overflow), 0);

        // simultaneous changes
        lane_data = '0;
        popped.delete();
        do_arm();
        for (int k = 0; k < 15; k++) begin
            if (k == 5) begin set_lane(0, 7); set_lane(2, 2); set_lane(4, 3); end
            cyc();
        end
        check_event("s2_e0", 0, 0, 7, 5);
        check_event("s2_e1", 1, 2, 2, 5);
        check_event("s2_e2", 2, 4, 3, 5);

        // backpressure and full FIFO
        ev_ready = 1'b0; lane_data = '0;
        do_arm();
        for (int n = 0; n < 9; n++) begin
            set_lane(0, n + 1);
            cyc(); cyc();
        end
        check("bp_level_full", 32'(level), 8);
        check("bp_overflow", 32'(overflow), 0);
        ev_ready = 1'b1;
        cyc();
        ev_ready = 1'b0;
        check("bp_level_after_pop", 32'(level), 8);

        // overwrite of a pending slot while full (run cycle index continues at 19)
        set_lane(2, 5);
        cyc();
        t2 = 20;
        set_lane(2, 6);
        cyc();
        cyc();
        check("ovf_set", 32'(overflow), 1);
        popped.delete();
        ev_ready = 1'b1;
        repeat (15) cyc();
        check("ovf_drain_count", popped.size(), 9);
        check_event("ovf_last", 8, 2, 6, t2);

        // saturation, then stop and drain
        ev_ready = 1'b0; lane_data = '0;
        do_arm();
        repeat (300) cyc();
        set_lane(0, 3);
        repeat (3) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        repeat (5) cyc();
        check("drain_busy", 32'(busy), 1);
        check("drain_level", 32'(level), 1);
        popped.delete();
        ev_ready = 1'b1;
        repeat (4) cyc();
        check("drain_idle", 32'(busy), 0);
        check_event("sat", 0, 0, 3, TS_MAX);
        set_lane(1, 5);
        repeat (4) cyc();
        check("idle_no_event", 32'(level), 0);

        // reset in the middle of activity
        ev_ready = 1'b0; lane_data = '0;
        do_arm();
        for (int i = 0; i < LANES; i++) set_lane(i, 1);
        cyc();
        repeat (5) cyc();
        check("mid_level", 32'(level), 5);
        set_lane(0, 2); set_lane(1, 2);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);
        popped.delete();
        ev_ready = 1'b1;
        do_arm();
        for (int k = 0; k < 10; k++) begin
            if (k == 3) set_lane(2, 4);
            cyc();
        end
        check_event("rearm", 0, 2, 4, 3);

        // random traffic against the model
        do_arm();
        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom_range(0, 599) == 0);
            arm      = ($urandom_range(0, 149) == 0);
            stop     = ($urandom_range(0, 119) == 0);
            ev_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < LANES; i++)
                if ($urandom_range(0, 9) == 0) set_lane(i, int'($urandom_range(0, 7)));
            cyc();
        end
        rst = 1'b0; arm = 1'b0; stop = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
